// File: rtl/div_pkg.sv
// Shared types and helpers for the radix-2 restoring divider.
// The state enum and the iteration-counter sizing live here so both the top and the bench agree.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } div_state_e;

   // Wide enough to hold the values 0..width.
   function automatic int cntWidth(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/restoring_divider_step.sv
// One combinational radix-2 restoring iteration on magnitudes.
// The partial remainder stays below the divisor, so the shifted value always fits in WIDTH+1 bits.
module div_step #(
   parameter int WIDTH = 10
) (
   input  logic [WIDTH:0]   partRem_i,
   input  logic             dividendMsb_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   partRem_o,
   output logic             quotBit_o
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   // The sign of the difference decides between keeping it and restoring.
   assign shifted   = {partRem_i, dividendMsb_i};
   assign diff      = shifted - {2'b00, divisor_i};
   assign quotBit_o = ~diff[WIDTH+1];
   assign partRem_o = quotBit_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider: WIDTH iterations on magnitudes, then a sign fix-up and result commit.
// Results and done are registered on the edge that leaves FINISH, so they appear together.
module restoring_divider
   import div_pkg::*;
#(
   parameter int WIDTH     = 10,
   parameter bit SIGNED_EN = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             signed_mode_i,
   input  logic [WIDTH-1:0] numerator_i,
   input  logic [WIDTH-1:0] denominator_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_by_zero_o
);

   localparam int             CW   = cntWidth(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH:0]   partRem_q, partRem_d;
   logic [WIDTH-1:0] dividend_q, dividend_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic             negQuot_q, negQuot_d;
   logic             negRem_q, negRem_d;
   logic             divZero_q, divZero_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             divByZero_q, divByZero_d;
   logic             done_q, done_d;

   logic             signedEff;
   logic             numNeg, denNeg, denIsZero;
   logic [WIDTH-1:0] numMag, denMag;
   logic [WIDTH:0]   stepRem;
   logic             stepQuot;

   assign signedEff = SIGNED_EN && signed_mode_i;
   assign numNeg    = signedEff && numerator_i[WIDTH-1];
   assign denNeg    = signedEff && denominator_i[WIDTH-1];
   assign denIsZero = (denominator_i == '0);
   assign numMag    = numNeg ? -numerator_i : numerator_i;
   assign denMag    = denNeg ? -denominator_i : denominator_i;

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .partRem_i    (partRem_q),
      .dividendMsb_i(dividend_q[WIDTH-1]),
      .divisor_i    (divisor_q),
      .partRem_o    (stepRem),
      .quotBit_o    (stepQuot)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         count_q     <= '0;
         partRem_q   <= '0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         negQuot_q   <= 1'b0;
         negRem_q    <= 1'b0;
         divZero_q   <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         divByZero_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         partRem_q   <= partRem_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         negQuot_q   <= negQuot_d;
         negRem_q    <= negRem_d;
         divZero_q   <= divZero_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         divByZero_q <= divByZero_d;
         done_q      <= done_d;
      end
   end

   // The done_q guard keeps a start coinciding with the done pulse from being taken.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      partRem_d   = partRem_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      negQuot_d   = negQuot_q;
      negRem_d    = negRem_q;
      divZero_d   = divZero_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      divByZero_d = divByZero_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i && !done_q) begin
               count_d    = '0;
               partRem_d  = '0;
               divisor_d  = denMag;
               negQuot_d  = numNeg ^ denNeg;
               negRem_d   = numNeg;
               divZero_d  = denIsZero;
               dividend_d = denIsZero ? numerator_i : numMag;
               state_d    = denIsZero ? FINISH : CALC;
            end
         end

         CALC: begin
            partRem_d  = stepRem;
            dividend_d = {dividend_q[WIDTH-2:0], stepQuot};
            count_d    = count_q + CW'(1);
            if (count_q == LAST) begin
               state_d = FINISH;
            end
         end

         FINISH: begin
            done_d      = 1'b1;
            divByZero_d = divZero_q;
            // Divide-by-zero keeps the raw numerator in the dividend register.
            if (divZero_q) begin
               quotient_d  = '1;
               remainder_d = dividend_q;
            end else begin
               quotient_d  = negQuot_q ? -dividend_q : dividend_q;
               remainder_d = negRem_q ? -partRem_q[WIDTH-1:0] : partRem_q[WIDTH-1:0];
            end
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy_o        = (state_q != IDLE);
   assign done_o        = done_q;
   assign quotient_o    = quotient_q;
   assign remainder_o   = remainder_q;
   assign div_by_zero_o = divByZero_q;

endmodule
